wb_stage: RTL
=============

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL have parameters: DATA_WIDTH, 32, datapath width; ADDR_WIDTH, 5, register index width.
REQ-002 Reset SHALL be rst, synchronous, active-high; the clock SHALL be clk.
REQ-003 Ports (name direction width meaning) SHALL be:
 clk  in  1  clock
 rst  in  1  synchronous active-high reset
 in_valid  in  1  upstream result valid
 in_ready  out  1  stage can accept
 in_dest  in  5  destination register index
 in_alu_res  in  32  ALU result (non-load)
 in_is_load  in  1  instruction is a load
 in_load_op  in  3  load type code
 in_addr_lo  in  2  load address bits [1:0]
 in_old_rt  in  32  prior rt value (LWL/LWR merge)
 mem_rvalid  in  1  load data valid
 mem_rdata  in  32  load data word
 rf_wen  out  1  register-file write enable
 rf_waddr  out  5  register-file write index
 rf_wdata  out  32  register-file write data
 retire_cnt  out  32  retired-instruction counter

Function
REQ-004 The FSM SHALL have states IDLE, WAIT_MEM and WRITE.
REQ-005 in_ready SHALL be 1 only in IDLE; a transfer occurs when in_valid && in_ready.
REQ-006 On a transfer, the block SHALL latch in_dest, in_alu_res, in_is_load, in_load_op, in_addr_lo and in_old_rt.
REQ-007 On a transfer with in_is_load=0, IDLE SHALL go to WRITE.
REQ-008 On a transfer with in_is_load=1, IDLE SHALL go to WAIT_MEM.
REQ-009 In WAIT_MEM, mem_rvalid=1 SHALL latch the aligned load result and go to WRITE; otherwise the FSM SHALL stay in WAIT_MEM indefinitely.
REQ-010 mem_rvalid SHALL be ignored in IDLE and WRITE.
REQ-011 In WRITE, rf_wen SHALL be 1 for exactly one cycle, with rf_waddr = latched dest and rf_wdata = the result; the FSM SHALL return to IDLE next cycle.
REQ-012 If the latched dest is 0, rf_wen SHALL stay 0 in WRITE; the instruction still retires.
REQ-013 Outside WRITE, rf_wen SHALL be 0; rf_waddr and rf_wdata SHALL hold their last values.
REQ-014 retire_cnt SHALL increment by 1 in every WRITE cycle and wrap from 0xFFFFFFFF to 0.
REQ-015 Latency SHALL be: ALU op, transfer cycle N -> rf_wen at N+1; load with mem_rvalid at cycle M -> rf_wen at M+1.
REQ-016 Throughput SHALL be one ALU result per 2 cycles maximum.
REQ-017 Load alignment codes SHALL be:
 - 000 LW: whole word.
 - 001 LB: byte at addr_lo, sign-extended.
 - 010 LBU: byte at addr_lo, zero-extended.
 - 011 LH: half selected by addr_lo[1], sign-extended.
 - 100 LHU: same half, zero-extended.
REQ-018 Byte lane k SHALL be mem_rdata[8k+7:8k] (little-endian).
REQ-019 Codes 101, 110 and 111, when not otherwise enabled, SHALL behave as LW.

Reset
REQ-020 rst SHALL force the FSM to IDLE and clear rf_wen, rf_waddr, rf_wdata, retire_cnt and all latched fields to 0, overriding any concurrent event.
REQ-021 rst asserted in WAIT_MEM or WRITE SHALL discard the in-flight instruction with no write and no retire count; a mem_rvalid arriving after reset SHALL be ignored.
REQ-022 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-023 Macro WB_UNALIGNED_LOAD_EN, when defined, SHALL enable LWL (101) and LWR (110), with k = addr_lo:
 - LWL: upper (k+1) bytes of the result = low (k+1) bytes of mem_rdata; remaining bytes from in_old_rt.
 - LWR: lower (4-k) bytes of the result = high (4-k) bytes of mem_rdata; remaining bytes from in_old_rt.
REQ-024 When WB_UNALIGNED_LOAD_EN is undefined, in_old_rt SHALL be unused and codes 101 and 110 SHALL act as LW.

Structure
REQ-025 Load-op codes and FSM state encodings SHALL be in shared package cpu_pkg.
REQ-026 Lane extraction, extension and merge SHALL be a combinational sub-module, load_align.

Verification
REQ-027 Reset: rst high 2 cycles -> rf_wen=0, retire_cnt=0, in_ready=1.
REQ-028 ALU: dest=5, alu_res=0x12345678 -> next cycle rf_wen=1, waddr=5, wdata=0x12345678; retire_cnt=1.
REQ-029 LB: addr_lo=2, mem_rdata=0x00800000 after 3 wait cycles -> wdata=0xFFFFFF80; LBU with same data -> 0x00000080.
REQ-030 dest=0: ALU op -> rf_wen stays 0, retire_cnt increments.
REQ-031 Reset mid-load: rst asserted in WAIT_MEM, then mem_rvalid -> no write, retire_cnt=0.
REQ-032 With WB_UNALIGNED_LOAD_EN, LWL: addr_lo=1, mem_rdata=0xAABBCCDD, old_rt=0x11223344 -> 0xCCDD3344; LWR: addr_lo=1 -> 0x11AABBCC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared load-op codes and write-back FSM state encodings.
package cpu_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [2:0] {
      LOP_LW   = 3'b000,
      LOP_LB   = 3'b001,
      LOP_LBU  = 3'b010,
      LOP_LH   = 3'b011,
      LOP_LHU  = 3'b100,
      LOP_LWL  = 3'b101,
      LOP_LWR  = 3'b110,
      LOP_RSVD = 3'b111
   } load_op_e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      WRITE    = 2'd2
   } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load lane extraction, sign/zero extension and LWL/LWR merge.
// LWL/LWR merging is only built when WB_UNALIGNED_LOAD_EN is defined.
module load_align
   import cpu_pkg::*;
(
   input  logic [2:0]        load_op_i,
   input  logic [1:0]        addr_lo_i,
   input  logic [WORD_W-1:0] rdata_i,
   input  logic [WORD_W-1:0] old_rt_i,
   output logic [WORD_W-1:0] result_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign byte_v = rdata_i[{addr_lo_i, 3'b000} +: 8];
   assign half_v = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

`ifdef WB_UNALIGNED_LOAD_EN
   logic [4:0]        lwl_shift;
   logic [5:0]        lwl_keep_shift;
   logic [4:0]        lwr_shift;
   logic [WORD_W-1:0] lwl_v;
   logic [WORD_W-1:0] lwr_v;

   // LWL places low (k+1) memory bytes at the top; LWR places high (4-k) bytes at the bottom.
   assign lwl_shift      = {~addr_lo_i, 3'b000};
   assign lwl_keep_shift = {({1'b0, addr_lo_i} + 3'd1), 3'b000};
   assign lwr_shift      = {addr_lo_i, 3'b000};
   assign lwl_v = (rdata_i << lwl_shift) | (old_rt_i & ({WORD_W{1'b1}} >> lwl_keep_shift));
   assign lwr_v = (rdata_i >> lwr_shift) | (old_rt_i & ~({WORD_W{1'b1}} >> lwr_shift));
`else
   logic unused_old_rt;
   assign unused_old_rt = ^old_rt_i;
`endif

   always_comb begin
      result_o = rdata_i;
      case (load_op_i)
         LOP_LB:  result_o = {{24{byte_v[7]}}, byte_v};
         LOP_LBU: result_o = {24'd0, byte_v};
         LOP_LH:  result_o = {{16{half_v[15]}}, half_v};
         LOP_LHU: result_o = {16'd0, half_v};
`ifdef WB_UNALIGNED_LOAD_EN
         LOP_LWL: result_o = lwl_v;
         LOP_LWR: result_o = lwr_v;
`endif
         default: result_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: accepts ALU/load results, aligns load data, writes the register file.
// Optional LWL/LWR support via WB_UNALIGNED_LOAD_EN (see load_align).
module wb_stage
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] in_dest,
   input  logic [DATA_WIDTH-1:0] in_alu_res,
   input  logic                  in_is_load,
   input  logic [2:0]            in_load_op,
   input  logic [1:0]            in_addr_lo,
   input  logic [DATA_WIDTH-1:0] in_old_rt,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic [31:0]           retire_cnt
);

   wb_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] dest_q;
   logic [DATA_WIDTH-1:0] res_q;
   logic                  is_load_q;
   logic [2:0]            op_q;
   logic [1:0]            lo_q;
   logic [DATA_WIDTH-1:0] old_q;
   logic [ADDR_WIDTH-1:0] waddr_hold_q;
   logic [DATA_WIDTH-1:0] wdata_hold_q;
   logic [31:0]           retire_q;
   logic [DATA_WIDTH-1:0] aligned;
   logic                  xfer;
   logic                  in_write;

   load_align u_align (
      .load_op_i (op_q),
      .addr_lo_i (lo_q),
      .rdata_i   (mem_rdata),
      .old_rt_i  (old_q),
      .result_o  (aligned)
   );

   assign xfer     = in_valid && in_ready;
   assign in_write = (state_q == WRITE);

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = in_is_load ? WAIT_MEM : WRITE;
         end
         WAIT_MEM: if (mem_rvalid && is_load_q) state_d = WRITE;
         WRITE:    state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         dest_q       <= '0;
         res_q        <= '0;
         is_load_q    <= 1'b0;
         op_q         <= '0;
         lo_q         <= '0;
         old_q        <= '0;
         waddr_hold_q <= '0;
         wdata_hold_q <= '0;
         retire_q     <= '0;
      end else begin
         state_q <= state_d;
         if (xfer) begin
            dest_q    <= in_dest;
            res_q     <= in_alu_res;
            is_load_q <= in_is_load;
            op_q      <= in_load_op;
            lo_q      <= in_addr_lo;
            old_q     <= in_old_rt;
         end
         if (state_q == WAIT_MEM && mem_rvalid) res_q <= aligned;
         // Outputs show the live result during WRITE and the last written one otherwise.
         if (in_write) begin
            waddr_hold_q <= dest_q;
            wdata_hold_q <= res_q;
            retire_q     <= retire_q + 32'd1;
         end
      end
   end

   assign rf_wen     = in_write && (dest_q != '0) && !rst;
   assign rf_waddr   = in_write ? dest_q : waddr_hold_q;
   assign rf_wdata   = in_write ? res_q  : wdata_hold_q;
   assign retire_cnt = retire_q;

endmodule
